mem_stream_reader: RTL and testbench

Read-side sequencer placed directly downstream of a `mem`/`lutmem`/`blockmem` instance. On a start command it walks a contiguous, wrapping address range, drives the memory's `rdaddress`, and absorbs the memory's one-cycle registered read latency. It presents the words in order as a valid/ready stream with full throughput and arbitrary backpressure. Used wherever a stored vector or matrix row must be streamed into a compute pipeline.

---
 rtl/mem_stream_reader.sv | 155 +++++++++++++++
 tb/tb_mem_stream_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Streams a contiguous, wrapping address range out of a one-cycle-latency memory
// as a valid/ready stream, using credit-based issue into a 3-entry output FIFO.
module mem_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 9,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_rdaddress,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    rdaddr_q, rdaddr_d;
    logic [CW-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]    accept_cnt_q, accept_cnt_d;
    logic             vld_a_q, vld_a_d;
    logic             vld_q_q, vld_q_d;
    logic [WIDTH-1:0] fifo_q [3];
    logic [WIDTH-1:0] fifo_d [3];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    logic             pop;
    logic             push;
    logic [2:0]       level;
    logic             credit_ok;
    logic             base_ok;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both 1; while out_valid=1 and out_ready=0 the word is held.
    assign out_valid     = (occ_q != 2'd0);
    assign out_data      = fifo_q[rd_ptr_q];
    assign mem_rdaddress = rdaddr_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == FIN);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdaddr_d     = rdaddr_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        vld_a_d      = 1'b0;
        vld_q_d      = vld_a_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;

        pop     = out_valid && out_ready;
        push    = vld_q_q;
        base_ok = ({1'b0, base} < DEPTH_W);
        // Slots already committed (buffered + in flight) after this cycle's pop.
        level     = 3'(occ_q) + 3'(vld_a_q) + 3'(vld_q_q) - 3'(pop);
        credit_ok = (level < 3'd3);

        unique case (state_q)
            IDLE: begin
                if (start && base_ok) begin
                    accept_cnt_d = count;
                    if (count == '0) begin
                        state_d = FIN;
                    end else begin
                        // The start cycle already issues the first read.
                        state_d     = RUN;
                        rdaddr_d    = base;
                        addr_d      = addr_inc(base);
                        issue_cnt_d = count - CW'(1);
                        vld_a_d     = 1'b1;
                    end
                end
            end
            RUN: begin
                if ((issue_cnt_q != '0) && credit_ok) begin
                    rdaddr_d    = addr_q;
                    addr_d      = addr_inc(addr_q);
                    issue_cnt_d = issue_cnt_q - CW'(1);
                    vld_a_d     = 1'b1;
                end
                if (pop) begin
                    accept_cnt_d = accept_cnt_q - CW'(1);
                    if (accept_cnt_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = mem_q;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rdaddr_q     <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            vld_a_q      <= 1'b0;
            vld_q_q      <= 1'b0;
            fifo_q       <= '{default: '0};
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            occ_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdaddr_q     <= rdaddr_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            vld_a_q      <= vld_a_d;
            vld_q_q      <= vld_q_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a registered-read memory model, table-driven
// transfers with a data scoreboard, and hand-written reset/command corner cases.
module tb_mem_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 9;
    localparam int AW    = 4;
    localparam int CW    = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base  = '0;
    logic [CW-1:0]    count = '0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_rdaddress;
    logic [WIDTH-1:0] mem_q = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    bit stalled_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;

    typedef struct {
        int b;
        int c;
        int mode;
        int poke;
        int exp_done;
        int exp_first;
        int exp_busy;
    } vec_t;

    vec_t vecs [8];

    mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base          (base),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .mem_rdaddress (mem_rdaddress),
        .mem_q         (mem_q),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    // Clock / memory model with one-cycle registered read.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_q <= mem[mem_rdaddress];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pops one expected word per accepted transfer.
    always @(negedge clock) begin
        if (mon_en) begin
            if (stalled_prev) begin
                check("stall_hold", int'({out_valid, out_data}), int'({1'b1, held}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", int'(out_data), -1);
                end else begin
                    check("stream_data", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            stalled_prev = out_valid && !out_ready;
            held         = out_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    function automatic bit ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Driver: called at #1 after an edge; start is sampled at the next edge (N).
    task automatic run_xfer(input int b, input int c, input int mode, input int poke,
                            output int done_k, output int first_v, output int busy_n);
        done_k  = -1;
        first_v = -1;
        busy_n  = 0;
        start     = 1'b1;
        base      = AW'(b);
        count     = CW'(c);
        out_ready = ready_for(mode, 0);
        if (c > 0 && b < DEPTH) begin
            for (int i = 0; i < c; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
        end
        @(posedge clock); #1;
        start = 1'b0;
        if (c > 0) check("rdaddr_base", int'(mem_rdaddress), b);
        for (int k = 0; k < 400; k++) begin
            if (busy) busy_n++;
            if (out_valid && first_v < 0) first_v = k;
            if (done) begin
                done_k = k;
                break;
            end
            out_ready = ready_for(mode, k + 1);
            start = (k == poke);
            if (k == poke) begin
                base  = AW'(5);
                count = CW'(2);
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        if (done_k < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            @(posedge clock); #1;
            check("done_one_cycle", int'({done, busy}), 0);
        end
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dk, fv, bn;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 1);

        vecs[0] = '{2, 4, 0, -1, 6,  2,  6};
        vecs[1] = '{7, 5, 0, -1, 7,  2,  7};
        vecs[2] = '{0, 9, 0, -1, 11, 2,  11};
        vecs[3] = '{0, 0, 0, -1, 0,  -1, 0};
        vecs[4] = '{4, 9, 1, -1, -2, -2, -2};
        vecs[5] = '{3, 9, 2, -1, -2, -2, -2};
        vecs[6] = '{8, 1, 0, -1, 3,  2,  3};
        vecs[7] = '{1, 6, 0, 2,  8,  2,  8};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_rdaddr", int'(mem_rdaddress), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        mon_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].b, vecs[v].c, vecs[v].mode, vecs[v].poke, dk, fv, bn);
            if (vecs[v].exp_done >= -1)  check($sformatf("v%0d_done_lat", v), dk, vecs[v].exp_done);
            if (vecs[v].exp_first >= -1) check($sformatf("v%0d_first_valid", v), fv, vecs[v].exp_first);
            if (vecs[v].exp_busy >= -1)  check($sformatf("v%0d_busy_cycles", v), bn, vecs[v].exp_busy);
        end

        // base out of range: command ignored.
        start = 1'b1; base = AW'(9); count = CW'(3);
        @(posedge clock); #1;
        start = 1'b0;
        check("oob_busy", int'(busy), 0);
        check("oob_done", int'(done), 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("oob_valid", int'({out_valid, busy}), 0);

        // Reset at N+3 of a count=6 transfer discards everything.
        mon_en = 1'b0;
        start = 1'b1; base = AW'(0); count = CW'(6); out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_valid", int'(out_valid), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_rdaddr", int'(mem_rdaddress), 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check("post_rst_quiet", int'({done, busy, out_valid}), 0);
        end
        mon_en = 1'b1;
        run_xfer(0, 2, 0, -1, dk, fv, bn);
        check("post_rst_done_lat", dk, 4);
        check("post_rst_first_valid", fv, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
